// File: rtl/sar_ctrl_pkg.sv
// Shared state encoding and width helpers for the SAR conversion controller.
package sar_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GO_WAIT = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } sar_state_e;

    localparam int NBITS_DEF       = 8;
    localparam int OSR_MAX_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    // The accumulator must hold 2^OSR_MAX full-scale samples without wrapping.
    function automatic int acc_width(input int nbits, input int osr_max);
        return nbits + osr_max;
    endfunction

    // The sample counter must reach 2^OSR_MAX itself, hence one extra bit.
    function automatic int cnt_width(input int osr_max);
        return osr_max + 1;
    endfunction

    function automatic int tmo_width(input int timeout_cyc);
        return (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
    endfunction

    localparam int ACC_W_DEF = acc_width(NBITS_DEF, OSR_MAX_DEF);
    localparam int CNT_W_DEF = cnt_width(OSR_MAX_DEF);
    localparam int TMO_W_DEF = tmo_width(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/sar_ctrl_outreg.sv
// One-entry output holding register with ready/valid handshake and sticky
// overrun flag for results that arrive while unread data is still held.
module sar_ctrl_outreg
    import sar_ctrl_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [NBITS-1:0] data_i,
    input  logic             ready_i,
    input  logic             clr_err_i,
    output logic [NBITS-1:0] dout_o,
    output logic             dout_valid_o,
    output logic             overrun_o
);

    logic [NBITS-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             accept, drop;

    always_comb begin
        accept  = load_i && (!valid_q || ready_i);
        drop    = load_i && valid_q && !ready_i;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (accept) begin
            dout_d  = data_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear must leave the flag set.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_err_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign overrun_o    = ovr_q;

endmodule

// File: rtl/sar_conv_ctrl.sv
// SAR ADC conversion controller: drives GO/VALID handshakes, averages 2^OSR
// samples per block and hands each average to a one-entry output register.
//   state    | meaning
//   IDLE     | waiting for EN or TRIG
//   GO_WAIT  | ADC_GO high, waiting for VALID, timeout counting down
//   CAPTURE  | add ADC_RESULT into accumulator, bump sample count
//   RELEASE  | wait for VALID low, then next sample or finish block
//   DONE     | present average to output register
module sar_conv_ctrl
    import sar_ctrl_pkg::*;
#(
    parameter int NBITS       = NBITS_DEF,
    parameter int OSR_MAX     = OSR_MAX_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             trig_i,
    input  logic [2:0]       osr_i,
    input  logic             clr_err_i,
    output logic             adc_go_o,
    input  logic             adc_valid_i,
    input  logic [NBITS-1:0] adc_result_i,
    output logic [NBITS-1:0] dout_o,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic             busy_o,
    output logic             err_timeout_o,
    output logic             overrun_o
);

    localparam int ACC_W = acc_width(NBITS, OSR_MAX);
    localparam int CNT_W = cnt_width(OSR_MAX);
    localparam int TMO_W = tmo_width(TIMEOUT_CYC);

    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       OSR_MAX_L = 3'(OSR_MAX);

    sar_state_e       state_q, state_d;
    logic [2:0]       osr_q, osr_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_tmo_q, err_tmo_d;

    logic [2:0]       osr_clamped;
    logic [CNT_W-1:0] cnt_target;
    logic             done_load;
    logic             tmo_evt;
    logic [NBITS-1:0] avg;

    assign osr_clamped = (osr_i > OSR_MAX_L) ? OSR_MAX_L : osr_i;
    assign cnt_target  = CNT_W'(1) << osr_q;
    assign avg         = NBITS'(acc_q >> osr_q);

    always_comb begin
        state_d   = state_q;
        osr_d     = osr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        done_load = 1'b0;
        tmo_evt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((en_i || trig_i) && !adc_valid_i) begin
                    state_d = ST_GO_WAIT;
                    osr_d   = osr_clamped;
                    acc_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = TMO_LOAD;
                end
            end
            ST_GO_WAIT: begin
                // A VALID arriving on the terminal cycle still counts as a sample.
                if (adc_valid_i) begin
                    state_d = ST_CAPTURE;
                end else if (tmo_q == '0) begin
                    tmo_evt = 1'b1;
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                acc_d   = acc_q + ACC_W'(adc_result_i);
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!adc_valid_i) begin
                    tmo_d   = TMO_LOAD;
                    state_d = (cnt_q < cnt_target) ? ST_GO_WAIT : ST_DONE;
                end
            end
            ST_DONE: begin
                done_load = 1'b1;
                if (en_i) begin
                    state_d = ST_GO_WAIT;
                    osr_d   = osr_clamped;
                    acc_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = TMO_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_tmo_d = err_tmo_q;
        if (tmo_evt) begin
            err_tmo_d = 1'b1;
        end else if (clr_err_i) begin
            err_tmo_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            osr_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            osr_q     <= osr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign adc_go_o      = (state_q == ST_GO_WAIT);
    assign busy_o        = (state_q != ST_IDLE);
    assign err_timeout_o = err_tmo_q;

    sar_ctrl_outreg #(
        .NBITS (NBITS)
    ) u_outreg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (done_load),
        .data_i       (avg),
        .ready_i      (dout_ready_i),
        .clr_err_i    (clr_err_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .overrun_o    (overrun_o)
    );

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Directed bench for sar_conv_ctrl with a behavioural SAR model and an
// expected-average scoreboard.
module tb_sar_conv_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       trig;
    logic [2:0] osr;
    logic       clr_err;
    logic       adc_go;
    logic       adc_valid;
    logic [7:0] adc_result;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       err_timeout;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] res_q[$];
    logic [7:0] exp_q[$];
    int         go_lat = 1;
    bit         never_valid = 1'b0;
    int         run = 0;

    sar_conv_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .trig_i       (trig),
        .osr_i        (osr),
        .clr_err_i    (clr_err),
        .adc_go_o     (adc_go),
        .adc_valid_i  (adc_valid),
        .adc_result_i (adc_result),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .busy_o       (busy),
        .err_timeout_o(err_timeout),
        .overrun_o    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SAR model: VALID rises in the go_lat-th GO cycle, falls once GO drops.
    always @(negedge clk) begin
        if (rst) begin
            run       = 0;
            adc_valid = 1'b0;
        end else if (adc_go) begin
            run = run + 1;
            if (run >= go_lat && !never_valid && !adc_valid) begin
                adc_valid  = 1'b1;
                adc_result = (res_q.size() > 0) ? res_q.pop_front() : 8'h00;
            end
        end else begin
            run       = 0;
            adc_valid = 1'b0;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_dout(input string tag);
        int         n;
        logic [7:0] e;
        n = 0;
        while (!dout_valid && n < 400) begin
            tick;
            n++;
        end
        chk({tag, "_valid"}, dout_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_dout"}, dout, e);
    endtask

    task automatic read_out;
        dout_ready = 1'b1;
        tick;
        dout_ready = 1'b0;
    endtask

    initial begin
        int n;
        int gocnt;
        int vcnt;
        int sum;

        rst = 1'b1; en = 1'b0; trig = 1'b0; osr = 3'd0; clr_err = 1'b0;
        dout_ready = 1'b0; adc_valid = 1'b0; adc_result = 8'h00;
        tick; tick; tick;
        chk("rst_go", adc_go, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dv", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        tick;

        // Single triggered conversion, OSR=0, VALID in the 8th GO cycle.
        go_lat = 8; osr = 3'd0;
        res_q.push_back(8'hA5); exp_q.push_back(8'hA5);
        trig = 1'b1;
        tick;
        trig = 1'b0;
        n = 1; gocnt = adc_go ? 1 : 0;
        while (!dout_valid && n < 100) begin
            tick;
            n++;
            if (adc_go) gocnt++;
        end
        chk("lat_cycles", n, 12);
        chk("lat_go_cycles", gocnt, 8);
        expect_dout("single");
        chk("single_idle", busy, 0);
        read_out;
        chk("single_dv_clr", dout_valid, 0);

        // Continuous mode OSR=2; EN dropped and TRIG pulsed during the 2nd block.
        go_lat = 2; osr = 3'd2; dout_ready = 1'b1;
        res_q.push_back(8'd10); res_q.push_back(8'd11); res_q.push_back(8'd12); res_q.push_back(8'd14);
        exp_q.push_back(8'd11);
        res_q.push_back(8'd20); res_q.push_back(8'd20); res_q.push_back(8'd21); res_q.push_back(8'd21);
        exp_q.push_back(8'd20);
        en = 1'b1;
        expect_dout("osr2_blk1");
        chk("osr2_no_idle", busy, 1);
        en = 1'b0; trig = 1'b1;
        tick;
        trig = 1'b0;
        expect_dout("osr2_blk2");
        chk("osr2_end_idle", busy, 0);
        repeat (6) tick;
        chk("trig_busy_ignored", busy, 0);
        chk("trig_busy_no_dv", dout_valid, 0);

        // OSR=4 full-scale samples.
        go_lat = 1; osr = 3'd4;
        for (int i = 0; i < 16; i++) res_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        trig = 1'b1;
        tick;
        trig = 1'b0;
        expect_dout("osr4_ff");

        // OSR=7 clamps to 4; a later OSR change must not affect the block.
        osr = 3'd7; sum = 0;
        for (int i = 0; i < 16; i++) begin
            res_q.push_back(8'(i * 13 + 5));
            sum += i * 13 + 5;
        end
        exp_q.push_back(8'(sum >> 4));
        tick;
        trig = 1'b1;
        tick;
        trig = 1'b0; osr = 3'd1;
        expect_dout("osr_clamp");
        tick;
        chk("osr_clamp_idle", busy, 0);

        // Overrun: consumer stalled, continuous OSR=0.
        dout_ready = 1'b0; osr = 3'd0; go_lat = 1;
        res_q.push_back(8'h11); res_q.push_back(8'h22); res_q.push_back(8'h33);
        res_q.push_back(8'h44); res_q.push_back(8'h55); res_q.push_back(8'h66);
        exp_q.push_back(8'h11);
        en = 1'b1;
        n = 0;
        while (!overrun && n < 200) begin
            tick;
            n++;
        end
        en = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            tick;
            n++;
        end
        chk("ovr_busy_done", busy, 0);
        expect_dout("ovr_held");
        chk("ovr_flag", overrun, 1);
        read_out;
        chk("ovr_dv_clr", dout_valid, 0);
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        chk("ovr_cleared", overrun, 0);
        res_q.delete();

        // Timeout: VALID never arrives; CLR_ERR held so set/clear collide.
        never_valid = 1'b1;
        trig = 1'b1;
        tick;
        trig = 1'b0; clr_err = 1'b1;
        n = 1; gocnt = adc_go ? 1 : 0;
        while (busy && n < 300) begin
            tick;
            n++;
            if (adc_go) gocnt++;
        end
        chk("tmo_go_cycles", gocnt, 64);
        chk("tmo_busy", busy, 0);
        chk("tmo_err_set_wins", err_timeout, 1);
        chk("tmo_no_dv", dout_valid, 0);
        tick;
        chk("tmo_err_cleared", err_timeout, 0);
        clr_err = 1'b0; never_valid = 1'b0;

        // Reset during RELEASE of the 3rd sample of an OSR=2 block.
        go_lat = 3; osr = 3'd2;
        res_q.push_back(8'h40); res_q.push_back(8'h41); res_q.push_back(8'h42); res_q.push_back(8'h43);
        trig = 1'b1;
        tick;
        trig = 1'b0;
        vcnt = 0; n = 0;
        while (vcnt < 3 && n < 200) begin
            tick;
            n++;
            if (adc_valid) vcnt++;
        end
        chk("rstmid_reach", vcnt, 3);
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk("rstmid_go", adc_go, 0);
        chk("rstmid_dout", dout, 0);
        chk("rstmid_dv", dout_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_err", err_timeout, 0);
        chk("rstmid_ovr", overrun, 0);
        rst = 1'b0;
        repeat (20) tick;
        chk("rstmid_no_dv", dout_valid, 0);
        chk("rstmid_no_dout", dout, 0);
        res_q.delete();

        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sar_conv_ctrl.md
SAR_CONV_CTRL -- requirements
Module: sar_conv_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 8, meaning ADC result width.
REQ-002 SHALL have parameter OSR_MAX, default 4, meaning max log2 oversampling ratio.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, meaning max CLK cycles to wait for ADC_VALID.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port EN  input  1  continuous conversion mode while high.
REQ-007 SHALL have port TRIG  input  1  one-cycle pulse; starts one averaged conversion when idle.
REQ-008 SHALL have port OSR  input  3  log2 samples per output, 0..OSR_MAX; larger values clamp to OSR_MAX.
REQ-009 SHALL have port CLR_ERR  input  1  clears sticky error flags.
REQ-010 SHALL have port ADC_GO  output  1  conversion request to SAR logic GO.
REQ-011 SHALL have port ADC_VALID  input  1  SAR logic VALID.
REQ-012 SHALL have port ADC_RESULT  input  NBITS  SAR logic RESULT.
REQ-013 SHALL have port DOUT  output  NBITS  averaged result.
REQ-014 SHALL have port DOUT_VALID  output  1  DOUT holds unread data.
REQ-015 SHALL have port DOUT_READY  input  1  consumer accepts DOUT when high with DOUT_VALID.
REQ-016 SHALL have port BUSY  output  1  high in any state except IDLE.
REQ-017 SHALL have ports ERR_TIMEOUT and OVERRUN, each output 1, sticky flags.

Function
REQ-018 SHALL implement FSM states IDLE, GO_WAIT, CAPTURE, RELEASE, DONE.
REQ-019 IDLE -> GO_WAIT when EN=1 or TRIG=1 and ADC_VALID=0; OSR latched (clamped) at this transition; accumulator and sample count cleared.
REQ-020 GO_WAIT: ADC_GO=1; -> CAPTURE on first cycle ADC_VALID=1.
REQ-021 CAPTURE (one cycle): ADC_GO=0; ADC_RESULT added into accumulator of width NBITS+OSR_MAX; sample count incremented.
REQ-022 RELEASE: ADC_GO=0; when ADC_VALID=0 -> GO_WAIT if count < 2^OSR, else DONE.
REQ-023 DONE (one cycle): average = accumulator >> OSR, truncated to NBITS; -> GO_WAIT (new block, OSR re-latched) if EN=1, else IDLE.
REQ-024 ADC_GO SHALL be high only in GO_WAIT; never two conversions without an intervening ADC_VALID=0 sample.
REQ-025 Output register is one-entry: in DONE, if DOUT_VALID=0 or DOUT_READY=1 that cycle, DOUT loads average and DOUT_VALID=1 next cycle.
REQ-026 In DONE with DOUT_VALID=1 and DOUT_READY=0: new average dropped, DOUT unchanged, OVERRUN set.
REQ-027 DOUT_VALID clears the cycle after a DOUT_READY handshake unless reloaded in the same cycle; DOUT stable while DOUT_VALID=1 and DOUT_READY=0.
REQ-028 Timeout counter SHALL count cycles in GO_WAIT; on reaching TIMEOUT_CYC: ERR_TIMEOUT set, ADC_GO drops, accumulator cleared, FSM -> IDLE, no DOUT produced.
REQ-029 TRIG while BUSY SHALL be ignored; EN falling mid-block SHALL let current block complete, then IDLE.
REQ-030 CLR_ERR SHALL clear both sticky flags; a set event in the same cycle wins.
REQ-031 Latency, OSR=0, ADC_VALID after k GO cycles: DOUT_VALID high k+4 cycles after TRIG cycle.

Reset
REQ-032 RST SHALL force state IDLE, ADC_GO=0, DOUT=0, DOUT_VALID=0, BUSY=0, ERR_TIMEOUT=0, OVERRUN=0, accumulator, count, timeout counter=0.
REQ-033 RST mid-conversion SHALL abandon the block with no DOUT update; ADC_GO low the cycle after RST sampled.

Structure
REQ-034 Shared package sar_ctrl_pkg SHALL hold the FSM state typedef and accumulator/counter width constants derived from NBITS, OSR_MAX, TIMEOUT_CYC.
REQ-035 Output holding register with overrun detection SHALL be sub-module sar_ctrl_outreg; FSM, accumulator, timeout stay in top.

Verification
REQ-036 OSR=0, TRIG, ADC model VALID after 8 GO cycles with RESULT=0xA5 -> one DOUT=0xA5, DOUT_VALID per REQ-031, then IDLE.
REQ-037 OSR=2, EN=1, results 10,11,12,14 -> DOUT=11 (47>>2), next block starts without returning to IDLE.
REQ-038 OSR=4, 16 samples of 0xFF -> DOUT=0xFF, no accumulator overflow.
REQ-039 DOUT_READY=0, EN=1, OSR=0 -> first result held, second dropped, OVERRUN=1; CLR_ERR clears it.
REQ-040 ADC model never asserts VALID -> ADC_GO high exactly 64 cycles, then ERR_TIMEOUT=1, BUSY=0.
REQ-041 RST asserted in RELEASE of sample 3 of OSR=2 block -> all outputs at reset values next cycle, no DOUT.
